// File: rtl/fft_pkg.sv
// Shared types, widths and helpers for the radix-2 FFT butterfly datapath.
package fft_pkg;

    localparam int DATA_W    = 16;
    localparam int TW_W      = 16;
    localparam int TW_FRAC   = 15;

    // Derived datapath widths: full product, product sum, scaled product, output sum.
    localparam int PROD_W    = DATA_W + TW_W;
    localparam int SUM_W     = PROD_W + 1;
    localparam int SCL_W     = SUM_W - TW_FRAC;
    localparam int OUT_SUM_W = SCL_W + 1;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Clamp a wide signed sum into the DATA_W two's-complement range.
    function automatic logic [DATA_W-1:0] sat_data(input logic signed [OUT_SUM_W-1:0] v);
        logic signed [OUT_SUM_W-1:0] max_v;
        logic signed [OUT_SUM_W-1:0] min_v;
        logic [DATA_W-1:0]           r;
        max_v = {{(OUT_SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        min_v = {{(OUT_SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > max_v) begin
            r = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (v < min_v) begin
            r = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// Pipelined complex multiplier W*B: registers the four signed partial
// products, then forms the full-precision real/imaginary sums from them.
module fft_cmul
    import fft_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    output logic signed [SUM_W-1:0]  p_re,
    output logic signed [SUM_W-1:0]  p_im
);

    logic signed [PROD_W-1:0] prod_rr_r;
    logic signed [PROD_W-1:0] prod_ii_r;
    logic signed [PROD_W-1:0] prod_ri_r;
    logic signed [PROD_W-1:0] prod_ir_r;

    // Stage-1 partial product registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_rr_r <= {PROD_W{1'b0}};
            prod_ii_r <= {PROD_W{1'b0}};
            prod_ri_r <= {PROD_W{1'b0}};
            prod_ir_r <= {PROD_W{1'b0}};
        end else begin
            prod_rr_r <= PROD_W'(w_re) * PROD_W'(b_re);
            prod_ii_r <= PROD_W'(w_im) * PROD_W'(b_im);
            prod_ri_r <= PROD_W'(w_re) * PROD_W'(b_im);
            prod_ir_r <= PROD_W'(w_im) * PROD_W'(b_re);
        end
    end

    // Full-precision product sums; one extra bit so nothing overflows.
    assign p_re = SUM_W'(prod_rr_r) - SUM_W'(prod_ii_r);
    assign p_im = SUM_W'(prod_ri_r) + SUM_W'(prod_ir_r);

endmodule

// File: rtl/fft_butterfly_unit.sv
// Radix-2 DIT butterfly: A' = A + W*B, B' = A - W*B with round-half-up
// Q1.15 scaling and saturating 16-bit outputs. Two-cycle fixed latency.
module fft_butterfly_unit
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data_ra,
    input  logic [DATA_W-1:0] i_data_ca,
    input  logic [DATA_W-1:0] i_data_rb,
    input  logic [DATA_W-1:0] i_data_cb,
    input  logic [TW_W-1:0]   i_twiddle_r,
    input  logic [TW_W-1:0]   i_twiddle_c,
    output logic [DATA_W-1:0] o_data_ra,
    output logic [DATA_W-1:0] o_data_ca,
    output logic [DATA_W-1:0] o_data_rb,
    output logic [DATA_W-1:0] o_data_cb
);

    localparam logic signed [SUM_W-1:0] ROUND_BIAS =
        {{(SUM_W-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};

    cplx_t                       a_r;
    logic signed [SUM_W-1:0]     p_re_s;
    logic signed [SUM_W-1:0]     p_im_s;
    logic signed [SUM_W-1:0]     p_re_bias_s;
    logic signed [SUM_W-1:0]     p_im_bias_s;
    logic signed [SCL_W-1:0]     p_re_scl_s;
    logic signed [SCL_W-1:0]     p_im_scl_s;
    logic signed [OUT_SUM_W-1:0] a_re_ext_s;
    logic signed [OUT_SUM_W-1:0] a_im_ext_s;
    logic signed [OUT_SUM_W-1:0] sum_ra_s;
    logic signed [OUT_SUM_W-1:0] sum_ca_s;
    logic signed [OUT_SUM_W-1:0] sum_rb_s;
    logic signed [OUT_SUM_W-1:0] sum_cb_s;

    fft_cmul u_cmul (
        .clk  (clk),
        .rst  (rst),
        .b_re (i_data_rb),
        .b_im (i_data_cb),
        .w_re (i_twiddle_r),
        .w_im (i_twiddle_c),
        .p_re (p_re_s),
        .p_im (p_im_s)
    );

    // Stage-1 copy of A, kept aligned with the partial products in fft_cmul.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_r <= {(2*DATA_W){1'b0}};
        end else begin
            a_r.re <= i_data_ra;
            a_r.im <= i_data_ca;
        end
    end

    // Round half up, drop the Q1.15 fraction, then form the butterfly sums.
    always_comb begin
        p_re_bias_s = p_re_s + ROUND_BIAS;
        p_im_bias_s = p_im_s + ROUND_BIAS;
        p_re_scl_s  = SCL_W'(p_re_bias_s >>> TW_FRAC);
        p_im_scl_s  = SCL_W'(p_im_bias_s >>> TW_FRAC);
        a_re_ext_s  = OUT_SUM_W'(a_r.re);
        a_im_ext_s  = OUT_SUM_W'(a_r.im);
        sum_ra_s    = a_re_ext_s + OUT_SUM_W'(p_re_scl_s);
        sum_ca_s    = a_im_ext_s + OUT_SUM_W'(p_im_scl_s);
        sum_rb_s    = a_re_ext_s - OUT_SUM_W'(p_re_scl_s);
        sum_cb_s    = a_im_ext_s - OUT_SUM_W'(p_im_scl_s);
    end

    // Stage-2 output registers holding the saturated results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_data_ra <= {DATA_W{1'b0}};
            o_data_ca <= {DATA_W{1'b0}};
            o_data_rb <= {DATA_W{1'b0}};
            o_data_cb <= {DATA_W{1'b0}};
        end else begin
            o_data_ra <= sat_data(sum_ra_s);
            o_data_ca <= sat_data(sum_ca_s);
            o_data_rb <= sat_data(sum_rb_s);
            o_data_cb <= sat_data(sum_cb_s);
        end
    end

endmodule

// File: tb/tb_fft_butterfly_unit.sv
// Directed and randomized self-checking bench for fft_butterfly_unit.
module tb_fft_butterfly_unit;

    typedef struct packed {
        logic [15:0] ra;
        logic [15:0] ca;
        logic [15:0] rb;
        logic [15:0] cb;
        logic [15:0] wr;
        logic [15:0] wi;
    } vec_t;

    typedef struct packed {
        logic [15:0] ra;
        logic [15:0] ca;
        logic [15:0] rb;
        logic [15:0] cb;
    } res_t;

    logic        clk;
    logic        rst;
    logic [15:0] i_data_ra, i_data_ca, i_data_rb, i_data_cb;
    logic [15:0] i_twiddle_r, i_twiddle_c;
    logic [15:0] o_data_ra, o_data_ca, o_data_rb, o_data_cb;

    int tests;
    int fails;

    fft_butterfly_unit dut (
        .clk         (clk),
        .rst         (rst),
        .i_data_ra   (i_data_ra),
        .i_data_ca   (i_data_ca),
        .i_data_rb   (i_data_rb),
        .i_data_cb   (i_data_cb),
        .i_twiddle_r (i_twiddle_r),
        .i_twiddle_c (i_twiddle_c),
        .o_data_ra   (o_data_ra),
        .o_data_ca   (o_data_ca),
        .o_data_rb   (o_data_rb),
        .o_data_cb   (o_data_cb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sx(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        logic [63:0] u;
        u = v;
        if (v > 64'sd32767) return 16'h7FFF;
        else if (v < -64'sd32768) return 16'h8000;
        else return u[15:0];
    endfunction

    // Reference butterfly: exact products, round half up, arithmetic shift, saturate.
    function automatic res_t bfly(input vec_t v);
        longint pr, pi, prs, pis;
        res_t   r;
        pr   = sx(v.wr) * sx(v.rb) - sx(v.wi) * sx(v.cb);
        pi   = sx(v.wr) * sx(v.cb) + sx(v.wi) * sx(v.rb);
        prs  = (pr + 64'sd16384) >>> 15;
        pis  = (pi + 64'sd16384) >>> 15;
        r.ra = sat16(sx(v.ra) + prs);
        r.ca = sat16(sx(v.ca) + pis);
        r.rb = sat16(sx(v.ra) - prs);
        r.cb = sat16(sx(v.ca) - pis);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        i_data_ra   = v.ra;
        i_data_ca   = v.ca;
        i_data_rb   = v.rb;
        i_data_cb   = v.cb;
        i_twiddle_r = v.wr;
        i_twiddle_c = v.wi;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t exp);
        check1({tag, ".ra"}, o_data_ra, exp.ra);
        check1({tag, ".ca"}, o_data_ca, exp.ca);
        check1({tag, ".rb"}, o_data_rb, exp.rb);
        check1({tag, ".cb"}, o_data_cb, exp.cb);
    endtask

    vec_t v_id, v_mj, v_sat, v_mix, v_rnd, prev_v;
    res_t r_id, r_mj, r_sat, r_mix, zero_r;

    initial begin
        tests  = 0;
        fails  = 0;
        zero_r = {64{1'b0}};

        // Directed vectors with hand-computed results.
        v_id  = {16'd1, 16'd2, 16'd3, 16'd4, 16'h7FFF, 16'h0000};
        r_id  = {16'd4, 16'd6, 16'hFFFE, 16'hFFFE};
        v_mj  = {16'd1, 16'd2, 16'd3, 16'd4, 16'h0000, 16'h8000};
        r_mj  = {16'd5, 16'hFFFF, 16'hFFFD, 16'd5};
        v_sat = {16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000};
        r_sat = {16'h7FFF, 16'hFFFE, 16'h0001, 16'h8000};
        // A=(100,-50), B=(-20,40), W=(0,0x7FFF): P=(-40,-20) -> A'=(60,-70), B'=(140,-30)
        v_mix = {16'd100, 16'hFFCE, 16'hFFEC, 16'd40, 16'h0000, 16'h7FFF};
        r_mix = {16'd60, 16'hFFBA, 16'd140, 16'hFFE2};

        // Reset held for two edges with nonzero inputs.
        rst = 1'b0;
        drive(v_sat);
        tick();
        tick();
        check_res("reset_hold", zero_r);

        // Release; first valid output two edges after the first sampled input.
        rst = 1'b1;
        drive(v_id);
        tick();
        check_res("first_not_ready", zero_r);
        tick();
        check_res("identity", r_id);

        // Back-to-back independent inputs, each result exactly two cycles later.
        drive(v_mj);
        tick();
        check_res("pipe_identity", r_id);
        drive(v_sat);
        tick();
        check_res("pipe_minus_j", r_mj);
        drive(v_mix);
        tick();
        check_res("pipe_saturate", r_sat);
        drive(v_id);
        tick();
        check_res("pipe_mix", r_mix);

        // One-edge reset pulse mid-stream discards in-flight data.
        drive(v_mj);
        tick();
        check_res("pre_pulse", r_id);
        drive(v_sat);
        rst = 1'b0;
        tick();
        check_res("pulse_edge", zero_r);
        rst = 1'b1;
        drive(v_mix);
        tick();
        check_res("pulse_flush", zero_r);
        drive(v_id);
        tick();
        check_res("pulse_resume", r_mix);
        tick();
        check_res("pulse_resume2", r_id);

        // Randomized bit-exact comparison against the reference model.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        prev_v = {96{1'b0}};
        for (int i = 0; i < 1000; i++) begin
            v_rnd = {$urandom, $urandom, $urandom};
            if (i % 16 == 0) begin
                v_rnd.wr = 16'h8000;
                v_rnd.rb = 16'h8000;
            end
            drive(v_rnd);
            tick();
            check_res("random", bfly(prev_v));
            prev_v = v_rnd;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_butterfly_unit.md
# fft_butterfly_unit

Radix-2 decimation-in-time FFT butterfly for 16-bit signed complex samples. Each cycle it takes two complex inputs A and B and one Q1.15 twiddle W, and produces A' = A + W·B and B' = A − W·B. It is the arithmetic core of each FFT stage; the stage controller feeds it operand pairs and twiddles from the twiddle LUT. The block is fully pipelined, accepts one butterfly per clock, and has a fixed latency of 2 cycles.

## Interface
- DATA_W, 16, width of data inputs/outputs, two's-complement integer
- TW_W, 16, twiddle width, signed Q1.15 (0x7FFF ≈ +1.0, 0x8000 = −1.0)
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset; one clock, synchronous, active-low (rst=0 resets on the next rising edge)
- i_data_ra  in  DATA_W  real part of A
- i_data_ca  in  DATA_W  imaginary part of A
- i_data_rb  in  DATA_W  real part of B
- i_data_cb  in  DATA_W  imaginary part of B
- i_twiddle_r  in  TW_W  real part of W
- i_twiddle_c  in  TW_W  imaginary part of W
- o_data_ra  out  DATA_W  real part of A'
- o_data_ca  out  DATA_W  imaginary part of A'
- o_data_rb  out  DATA_W  real part of B'
- o_data_cb  out  DATA_W  imaginary part of B'

## Operation
- Complex product P = W·B:
  - Pr = Wr·Br − Wi·Bi
  - Pi = Wr·Bi + Wi·Br
  - The four 16×16 partial products are full 32-bit signed values; each sum is computed in 33 bits.
- Scaling: add 2^14 (round half up), then arithmetic shift right by 15. Keep the 18-bit result, with no intermediate truncation.
- Output sums: A'r = Ar + Pr, A'i = Ai + Pi, B'r = Ar − Pr, B'i = Ai − Pi, each computed in 19 bits.
- Each output saturates to 16 bits: values above 32767 become 0x7FFF; values below −32768 become 0x8000. Saturation never wraps.
- Consequence of rounding: W = 0x7FFF reproduces B exactly for small |B|, so A' = A+B and B' = A−B.
- No scaling by 1/2 per stage; overflow control belongs to the FFT controller.
- No handshake: every cycle's inputs are consumed, and outputs are valid 2 cycles later.

## Timing
- Stage 1, at edge n: register the four partial products and a copy of A.
- Stage 2, at edge n+1: round/shift, add/subtract, saturate, register the outputs.
- Inputs sampled at edge n appear on the outputs after edge n+1, i.e. a latency of 2 cycles. Throughput is 1 butterfly per cycle and back-to-back inputs are independent.
- Reset: while rst=0 at a rising edge, all pipeline registers and all four outputs go to 0x0000.
- Reset asserted mid-operation discards in-flight data.
- After release, the first valid output appears 2 edges after the first sampled input. Outputs are 0 (not X) until then.
- All outputs come directly from registers; there is no combinational input-to-output path.

## Structure
- Shared package fft_pkg holds:
  - DATA_W, TW_W, TW_FRAC=15
  - the complex sample typedef (struct of real and imag, each DATA_W)
  - a saturate-to-DATA_W function
- Sub-module fft_cmul: a pipelined complex multiplier producing the registered 33-bit Pr/Pi sums, with stage-1 registers inside it.
- Rounding, add/sub and saturation live in the top level.

## Test plan
- Identity twiddle: A=(1,2), B=(3,4), W=(0x7FFF,0) → after 2 cycles A'=(4,6), B'=(−2,−2) = (0xFFFE,0xFFFE).
- −j twiddle: A=(1,2), B=(3,4), W=(0,0x8000) → P=(4,−3), A'=(5,−1), B'=(−3,5).
- Saturation: A=(0x7FFF,0x8000), B=(0x7FFF,0x7FFF), W=(0x7FFF,0) → P=(32766,32766), A'=(0x7FFF,−2), B'=(1,0x8000).
- Pipelining: drive three different input sets on consecutive cycles → three matching results on consecutive cycles, each exactly 2 cycles after its input.
- Reset: hold rst=0 for 2 edges with nonzero inputs → all outputs 0x0000. Pulse rst=0 for one edge in mid-stream → outputs 0 for the affected slots, then correct results resume 2 cycles after release.
- Randomized check: 1000 random A, B, W against a reference model using the same round-half-up and saturation → bit-exact match.
